i2c_slave_core: RTL and testbench

- Synthesizable I2C responder (slave) for the opposite end of the bus from i2c_master_top.
- Holds a byte-addressed register memory and implements the standard pointer protocol:
  - write: START, {SADR,W}, pointer byte, data bytes...
  - read: START/Sr, {SADR,R}, data bytes..., with the pointer auto-incrementing.
- Sits on the same open-drain scl/sda nets as the master, using the same pad/padoen convention, and replaces the behavioural slave model in system benches.

---
 rtl/i2c_slave_core.sv | 253 +++++++++++++++++++++++++
 tb/tb_i2c_slave_core.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_core.sv
// I2C responder with a byte-addressed register file and an auto-incrementing pointer.
// Master writes: START, {SADR,W}, pointer, data... ; reads: START/Sr, {SADR,R}, data...
// scl is never driven (no clock stretching); sda is open-drain through sda_padoen_o.
// Handshake: wr_stb_o is a one-cycle valid with no ready; wr_adr_o/wr_dat_o are
// meaningful only in the cycle wr_stb_o is high, and the sink must accept every pulse.
// FILT must be at least 2.
module i2c_slave_core #(
    parameter logic [6:0] SADR   = 7'b0010000,
    parameter int         MEM_AW = 4,
    parameter int         FILT   = 3
) (
    input  logic              wb_clk_i,
    input  logic              arst_i,
    input  logic              scl_pad_i,
    output logic              scl_pad_o,
    output logic              scl_padoen_o,
    input  logic              sda_pad_i,
    output logic              sda_pad_o,
    output logic              sda_padoen_o,
    input  logic [MEM_AW-1:0] host_adr_i,
    output logic [7:0]        host_dat_o,
    output logic              wr_stb_o,
    output logic [MEM_AW-1:0] wr_adr_o,
    output logic [7:0]        wr_dat_o,
    output logic              busy_o
);

    localparam int DEPTH = 2 ** MEM_AW;
    localparam logic [MEM_AW-1:0] PTR_ONE = 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        WR_PTR   = 3'd3,
        WR_ACK   = 3'd4,
        WR_DATA  = 3'd5,
        RD_DATA  = 3'd6,
        RD_ACK   = 3'd7
    } state_t;

    // ---------------- input conditioning ----------------
    logic            scl_s1, scl_s2, sda_s1, sda_s2;
    logic [FILT-2:0] scl_hist, sda_hist;
    logic [FILT-1:0] scl_win, sda_win;
    logic            scl_f, sda_f, scl_p, sda_p;
    logic            scl_rise, scl_fall, sda_rise, sda_fall;
    logic            start_c, stop_c;

    // The current synchronized sample plus FILT-1 older ones form the filter window
    assign scl_win = {scl_hist, scl_s2};
    assign sda_win = {sda_hist, sda_s2};

    // Synchronize pads, filter glitches, and keep the previous filtered level for edge detection
    always_ff @(posedge wb_clk_i or posedge arst_i) begin
        if (arst_i) begin
            scl_s1   <= 1'b1;
            scl_s2   <= 1'b1;
            sda_s1   <= 1'b1;
            sda_s2   <= 1'b1;
            scl_hist <= '1;
            sda_hist <= '1;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
            scl_p    <= 1'b1;
            sda_p    <= 1'b1;
        end else begin
            scl_s1   <= scl_pad_i;
            scl_s2   <= scl_s1;
            sda_s1   <= sda_pad_i;
            sda_s2   <= sda_s1;
            scl_hist <= scl_win[FILT-2:0];
            sda_hist <= sda_win[FILT-2:0];
            if (&scl_win) scl_f <= 1'b1;
            else if (~|scl_win) scl_f <= 1'b0;
            if (&sda_win) sda_f <= 1'b1;
            else if (~|sda_win) sda_f <= 1'b0;
            scl_p    <= scl_f;
            sda_p    <= sda_f;
        end
    end

    assign scl_rise = scl_f & ~scl_p;
    assign scl_fall = ~scl_f & scl_p;
    assign sda_rise = sda_f & ~sda_p;
    assign sda_fall = ~sda_f & sda_p;
    assign start_c  = sda_fall & scl_f;
    assign stop_c   = sda_rise & scl_f;

    // ---------------- datapath registers ----------------
    state_t            state_q, state_d;
    logic [7:0]        shreg_q;
    logic [3:0]        bitcnt_q;
    logic              ack_ph_q;
    logic              rw_q;
    logic [MEM_AW-1:0] ptr_q;
    logic              sda_oe_q, sda_oe_d;
    logic [7:0]        mem [DEPTH];
    logic [7:0]        rx_byte, rd_byte;
    logic              byte_done, addr_match;

    assign rx_byte    = {shreg_q[6:0], sda_f};
    assign rd_byte    = mem[ptr_q];
    assign byte_done  = scl_rise && (bitcnt_q == 4'd7);
    assign addr_match = (rx_byte[7:1] == SADR);

    assign scl_pad_o    = 1'b0;
    assign scl_padoen_o = 1'b1;
    assign sda_pad_o    = 1'b0;
    assign sda_padoen_o = sda_oe_q;
    assign host_dat_o   = mem[host_adr_i];

    // FSM state register
    always_ff @(posedge wb_clk_i or posedge arst_i) begin
        if (arst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: bus conditions override everything, then per-state bit handling
    always_comb begin
        state_d = state_q;
        if (start_c) begin
            state_d = ADDR;
        end else if (stop_c) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                ADDR:     if (byte_done) state_d = addr_match ? ADDR_ACK : IDLE;
                ADDR_ACK: if (scl_fall && ack_ph_q) state_d = rw_q ? RD_DATA : WR_PTR;
                WR_PTR:   if (byte_done) state_d = WR_ACK;
                WR_ACK:   if (scl_fall && ack_ph_q) state_d = WR_DATA;
                WR_DATA:  if (byte_done) state_d = WR_ACK;
                RD_DATA:  if (scl_fall && (bitcnt_q == 4'd8)) state_d = RD_ACK;
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_f) state_d = IDLE;
                    end else if (scl_fall && ack_ph_q) begin
                        state_d = RD_DATA;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // FSM output: next sda enable, changing only on the clock after a filtered scl fall
    always_comb begin
        sda_oe_d = sda_oe_q;
        if (start_c || stop_c) begin
            sda_oe_d = 1'b1;
        end else begin
            case (state_q)
                ADDR_ACK: if (scl_fall) sda_oe_d = ack_ph_q ? (rw_q ? rd_byte[7] : 1'b1) : 1'b0;
                WR_ACK:   if (scl_fall) sda_oe_d = ack_ph_q;
                RD_DATA:  if (scl_fall) sda_oe_d = (bitcnt_q == 4'd8) ? 1'b1 : shreg_q[7];
                RD_ACK:   if (scl_fall && ack_ph_q) sda_oe_d = rd_byte[7];
                default:  sda_oe_d = sda_oe_q;
            endcase
        end
    end

    // Shift register, bit counter, pointer, memory and commit strobe
    always_ff @(posedge wb_clk_i or posedge arst_i) begin
        if (arst_i) begin
            shreg_q  <= 8'h00;
            bitcnt_q <= 4'd0;
            ack_ph_q <= 1'b0;
            rw_q     <= 1'b0;
            ptr_q    <= '0;
            sda_oe_q <= 1'b1;
            busy_o   <= 1'b0;
            wr_stb_o <= 1'b0;
            wr_adr_o <= '0;
            wr_dat_o <= 8'h00;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
        end else begin
            sda_oe_q <= sda_oe_d;
            wr_stb_o <= 1'b0;
            if (start_c || stop_c) begin
                bitcnt_q <= 4'd0;
                ack_ph_q <= 1'b0;
                if (stop_c) busy_o <= 1'b0;
            end else begin
                case (state_q)
                    ADDR, WR_PTR, WR_DATA: begin
                        if (scl_rise) begin
                            shreg_q  <= rx_byte;
                            bitcnt_q <= bitcnt_q + 4'd1;
                            if (bitcnt_q == 4'd7) begin
                                bitcnt_q <= 4'd0;
                                ack_ph_q <= 1'b0;
                                if (state_q == ADDR) begin
                                    busy_o <= addr_match;
                                    if (addr_match) rw_q <= rx_byte[0];
                                end else if (state_q == WR_PTR) begin
                                    ptr_q <= rx_byte[MEM_AW-1:0];
                                end else begin
                                    mem[ptr_q] <= rx_byte;
                                    ptr_q      <= ptr_q + PTR_ONE;
                                    wr_stb_o   <= 1'b1;
                                    wr_adr_o   <= ptr_q;
                                    wr_dat_o   <= rx_byte;
                                end
                            end
                        end
                    end
                    ADDR_ACK, WR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_ph_q) begin
                                ack_ph_q <= 1'b1;
                            end else begin
                                ack_ph_q <= 1'b0;
                                bitcnt_q <= 4'd0;
                                if (state_q == ADDR_ACK && rw_q) begin
                                    // MSB goes out now, so the shifter holds the remaining bits
                                    shreg_q  <= {rd_byte[6:0], 1'b0};
                                    bitcnt_q <= 4'd1;
                                end
                            end
                        end
                    end
                    RD_DATA: begin
                        if (scl_fall) begin
                            if (bitcnt_q == 4'd8) begin
                                bitcnt_q <= 4'd0;
                                ack_ph_q <= 1'b0;
                            end else begin
                                shreg_q  <= {shreg_q[6:0], 1'b0};
                                bitcnt_q <= bitcnt_q + 4'd1;
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            if (sda_f) begin
                                busy_o <= 1'b0;
                            end else begin
                                ack_ph_q <= 1'b1;
                                ptr_q    <= ptr_q + PTR_ONE;
                            end
                        end else if (scl_fall && ack_ph_q) begin
                            ack_ph_q <= 1'b0;
                            shreg_q  <= {rd_byte[6:0], 1'b0};
                            bitcnt_q <= 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_core.sv
// Directed bench for i2c_slave_core: the bench plays the bus master on open-drain nets.
module tb_i2c_slave_core;

    localparam int T = 20;   // quarter bit time in clocks

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic [3:0] host_adr = 4'd0;

    logic       scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o;
    logic [7:0] host_dat;
    logic       wr_stb;
    logic [3:0] wr_adr;
    logic [7:0] wr_dat;
    logic       busy;
    logic       scl_line, sda_line;

    int checks = 0;
    int failures = 0;
    logic [11:0] exp_q[$];

    assign scl_line = m_scl & (scl_padoen_o | scl_pad_o);
    assign sda_line = m_sda & (sda_padoen_o | sda_pad_o);

    i2c_slave_core dut (
        .wb_clk_i     (clk),
        .arst_i       (arst),
        .scl_pad_i    (scl_line),
        .scl_pad_o    (scl_pad_o),
        .scl_padoen_o (scl_padoen_o),
        .sda_pad_i    (sda_line),
        .sda_pad_o    (sda_pad_o),
        .sda_padoen_o (sda_padoen_o),
        .host_adr_i   (host_adr),
        .host_dat_o   (host_dat),
        .wr_stb_o     (wr_stb),
        .wr_adr_o     (wr_adr),
        .wr_dat_o     (wr_dat),
        .busy_o       (busy)
    );

    // clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every commit strobe must match the next expected {adr,dat}
    always @(negedge clk) begin
        if (wr_stb === 1'b1) begin
            if (exp_q.size() == 0) chk("wr_stb_unexpected", {31'd0, wr_stb}, 32'd0);
            else chk("wr_stb_rec", {20'd0, wr_adr, wr_dat}, {20'd0, exp_q.pop_front()});
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // one scl period starting and ending with scl low; samples line and slave enable mid-high
    task automatic bit_xfer(input logic b, output logic rd, output logic oe_mid);
        wait_cyc(T);
        m_sda = b;
        wait_cyc(T);
        m_scl = 1'b1;
        wait_cyc(T);
        rd = sda_line;
        oe_mid = sda_padoen_o;
        wait_cyc(T);
        m_scl = 1'b0;
    endtask

    task automatic i2c_start();
        wait_cyc(T);
        m_sda = 1'b1;
        wait_cyc(T);
        m_scl = 1'b1;
        wait_cyc(2 * T);
        m_sda = 1'b0;
        wait_cyc(2 * T);
        m_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_cyc(T);
        m_sda = 1'b0;
        wait_cyc(T);
        m_scl = 1'b1;
        wait_cyc(2 * T);
        m_sda = 1'b1;
        wait_cyc(2 * T);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r, o;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], r, o);
        bit_xfer(1'b1, ack, o);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d, output logic rel);
        logic r, o;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, r, o);
            d[i] = r;
        end
        bit_xfer(nack, r, rel);
    endtask

    task automatic peek(input logic [3:0] a, output logic [7:0] d);
        host_adr = a;
        #1;
        d = host_dat;
    endtask

    initial begin
        logic       ack, rel;
        logic [7:0] d;

        // reset
        wait_cyc(5);
        chk("rst_sda_oe", {31'd0, sda_padoen_o}, 32'd1);
        chk("rst_scl_oe", {31'd0, scl_padoen_o}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wr_stb", {31'd0, wr_stb}, 32'd0);
        for (int a = 0; a < 16; a++) begin
            peek(4'(a), d);
            chk("rst_mem", {24'd0, d}, 32'd0);
        end
        arst = 1'b0;
        wait_cyc(20);

        // write 0xA5, 0x5A starting at pointer 1
        exp_q.push_back({4'h1, 8'hA5});
        exp_q.push_back({4'h2, 8'h5A});
        i2c_start();
        write_byte(8'h20, ack); chk("wr_addr_ack", {31'd0, ack}, 32'd0);
        chk("wr_busy", {31'd0, busy}, 32'd1);
        write_byte(8'h01, ack); chk("wr_ptr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'hA5, ack); chk("wr_d0_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h5A, ack); chk("wr_d1_ack", {31'd0, ack}, 32'd0);
        chk("wr_busy_before_stop", {31'd0, busy}, 32'd1);
        i2c_stop();
        chk("wr_busy_after_stop", {31'd0, busy}, 32'd0);
        peek(4'h1, d); chk("mem1", {24'd0, d}, 32'hA5);
        peek(4'h2, d); chk("mem2", {24'd0, d}, 32'h5A);
        peek(4'h0, d); chk("mem0", {24'd0, d}, 32'h00);

        // read back with repeated start
        i2c_start();
        write_byte(8'h20, ack); chk("rd_addr_w_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h01, ack); chk("rd_ptr_ack", {31'd0, ack}, 32'd0);
        i2c_start();
        write_byte(8'h21, ack); chk("rd_addr_r_ack", {31'd0, ack}, 32'd0);
        read_byte(1'b0, d, rel);
        chk("rd_byte0", {24'd0, d}, 32'hA5);
        chk("rd_rel_ack", {31'd0, rel}, 32'd1);
        read_byte(1'b1, d, rel);
        chk("rd_byte1", {24'd0, d}, 32'h5A);
        chk("rd_rel_nack", {31'd0, rel}, 32'd1);
        chk("rd_busy_after_nack", {31'd0, busy}, 32'd0);
        i2c_stop();

        // address mismatch
        i2c_start();
        write_byte(8'h40, ack); chk("mm_nack", {31'd0, ack}, 32'd1);
        chk("mm_busy", {31'd0, busy}, 32'd0);
        i2c_stop();
        peek(4'h1, d); chk("mm_mem1", {24'd0, d}, 32'hA5);
        peek(4'h2, d); chk("mm_mem2", {24'd0, d}, 32'h5A);

        // pointer wrap on write and read
        exp_q.push_back({4'hF, 8'h11});
        exp_q.push_back({4'h0, 8'h22});
        i2c_start();
        write_byte(8'h20, ack); chk("wrap_addr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h0F, ack); chk("wrap_ptr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h11, ack); chk("wrap_d0_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h22, ack); chk("wrap_d1_ack", {31'd0, ack}, 32'd0);
        i2c_stop();
        peek(4'hF, d); chk("wrap_memF", {24'd0, d}, 32'h11);
        peek(4'h0, d); chk("wrap_mem0", {24'd0, d}, 32'h22);
        i2c_start();
        write_byte(8'h20, ack);
        write_byte(8'h0F, ack);
        i2c_start();
        write_byte(8'h21, ack); chk("wrap_rd_addr_ack", {31'd0, ack}, 32'd0);
        read_byte(1'b0, d, rel); chk("wrap_rd0", {24'd0, d}, 32'h11);
        read_byte(1'b1, d, rel); chk("wrap_rd1", {24'd0, d}, 32'h22);
        i2c_stop();

        // STOP after 4 data bits: nothing committed
        i2c_start();
        write_byte(8'h20, ack);
        write_byte(8'h03, ack); chk("abort_ptr_ack", {31'd0, ack}, 32'd0);
        bit_xfer(1'b1, ack, rel);
        bit_xfer(1'b0, ack, rel);
        bit_xfer(1'b1, ack, rel);
        bit_xfer(1'b1, ack, rel);
        i2c_stop();
        chk("abort_busy", {31'd0, busy}, 32'd0);
        peek(4'h3, d); chk("abort_mem3", {24'd0, d}, 32'h00);

        // reset while the slave drives a 0 read bit (mem[0]=0x22, MSB 0)
        i2c_start();
        write_byte(8'h20, ack);
        write_byte(8'h00, ack);
        i2c_start();
        write_byte(8'h21, ack); chk("rst_rd_addr_ack", {31'd0, ack}, 32'd0);
        wait_cyc(T);
        chk("rst_rd_bit_driven", {31'd0, sda_padoen_o}, 32'd0);
        arst = 1'b1;
        #1;
        chk("rst_rd_sda_released", {31'd0, sda_padoen_o}, 32'd1);
        wait_cyc(3);
        chk("rst_rd_busy", {31'd0, busy}, 32'd0);
        peek(4'h0, d); chk("rst_rd_mem0", {24'd0, d}, 32'h00);
        arst = 1'b0;
        m_sda = 1'b1;
        wait_cyc(T);
        m_scl = 1'b1;
        wait_cyc(4 * T);

        // a fresh transaction after reset release
        exp_q.push_back({4'h5, 8'h77});
        i2c_start();
        write_byte(8'h20, ack); chk("post_addr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h05, ack); chk("post_ptr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h77, ack); chk("post_d0_ack", {31'd0, ack}, 32'd0);
        i2c_stop();
        peek(4'h5, d); chk("post_mem5", {24'd0, d}, 32'h77);

        wait_cyc(10);
        chk("exp_q_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
